// File: rtl/scaler_stream_if.sv
// Stream interface for scaler_stream_core: frame control, pixel input and pixel output.
// The slave modport is the core's view; the master modport is the driver/sink view.
interface scaler_stream_if #(
  parameter int PIX_W = 8
);
  logic             start;
  logic [1:0]       mode;
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] in_pixel;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] out_pixel;
  logic             out_last;
  logic             busy;
  logic             done;

  modport slave (
    input  start, mode, in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_pixel, out_last, busy, done
  );

  modport master (
    output start, mode, in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_pixel, out_last, busy, done
  );
endinterface

// File: rtl/scaler_stream_core.sv
// scaler_stream_core: streaming frame resampler (pass / 2x decimate / 2x2 average / 2x zoom).
// One IMG_W-entry line buffer holds pair sums (average) or a full row (zoom replay).
// Optional feature macro: AVG_ROUND_EN -- average mode adds 2 before the >>2 (round half up);
// when undefined the average truncates.
module scaler_stream_core #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 320,
  parameter int IMG_H = 240
) (
  input  logic            clk,
  input  logic            rst,
  scaler_stream_if.slave  s
);

  if ((IMG_W % 2) != 0 || IMG_W < 2) begin : g_bad_img_w
    $error("scaler_stream_core: IMG_W must be even and >= 2");
  end
  if ((IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_img_h
    $error("scaler_stream_core: IMG_H must be even and >= 2");
  end

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  localparam int MW = PIX_W + 1;
  localparam int SW = PIX_W + 2;

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [XW-1:0] X_PEN  = XW'(IMG_W - 2);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [YW-1:0] Y_PEN  = YW'(IMG_H - 2);

`ifdef AVG_ROUND_EN
  localparam logic [SW-1:0] AVG_RND = SW'(2);
`else
  localparam logic [SW-1:0] AVG_RND = SW'(0);
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_REPLAY, ST_FLUSH} state_t;
  typedef enum logic [1:0] {M_PASS = 2'b00, M_DEC = 2'b01, M_AVG = 2'b10, M_ZOOM = 2'b11} mode_t;

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic             in_done_q, in_done_d;   // final input pixel of the frame consumed
  logic             dup_q, dup_d;           // zoom: second horizontal copy still owed
  logic             row_end_q, row_end_d;   // zoom: the owed copy closes a row
  logic [XW-1:0]    rep_idx_q, rep_idx_d;
  logic             rep_ph_q, rep_ph_d;
  logic [PIX_W-1:0] prev_q, prev_d;
  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] out_pixel_q, out_pixel_d;
  logic             out_last_q, out_last_d;
  logic             done_q, done_d;

  logic [MW-1:0]    line_buf [IMG_W];
  logic [MW-1:0]    rd_q;
  logic             wr_en;
  logic [XW-1:0]    wr_addr;
  logic [MW-1:0]    wr_data;
  logic [XW-1:0]    rd_addr;

  logic             out_free;
  logic             drop;
  logic             in_ready;
  logic             accept;
  logic             at_x_last;
  logic             at_y_last;
  logic [MW-1:0]    pair_sum;
  logic [SW-1:0]    avg_sum;
  logic [PIX_W-1:0] avg_pix;
  logic             ld;
  logic [PIX_W-1:0] ld_pix;
  logic             ld_last;

  assign out_free  = !out_valid_q || s.out_ready;
  assign at_x_last = (x_q == X_LAST);
  assign at_y_last = (y_q == Y_LAST);
  assign pair_sum  = {1'b0, prev_q} + {1'b0, s.in_pixel};
  assign avg_sum   = {1'b0, rd_q} + {2'b00, prev_q} + {2'b00, s.in_pixel} + AVG_RND;
  assign avg_pix   = PIX_W'(avg_sum >> 2);

  // Pixels that produce no output are dropped and never wait on the output register.
  always_comb begin
    drop = 1'b0;
    case (mode_q)
      M_DEC:   drop = x_q[0] || y_q[0];
      M_AVG:   drop = !(x_q[0] && y_q[0]);
      default: drop = 1'b0;
    endcase
  end

  assign in_ready = (state_q == ST_RUN) && !dup_q && (drop || out_free);
  assign accept   = s.in_valid && in_ready;

  // Next-state, counters, line-buffer write and output-register load.
  always_comb begin
    // NOTE: every signal gets its default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    mode_d      = mode_q;
    x_d         = x_q;
    y_d         = y_q;
    in_done_d   = in_done_q;
    dup_d       = dup_q;
    row_end_d   = row_end_q;
    rep_idx_d   = rep_idx_q;
    rep_ph_d    = rep_ph_q;
    prev_d      = prev_q;
    done_d      = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = x_q;
    wr_data     = '0;
    ld          = 1'b0;
    ld_pix      = out_pixel_q;
    ld_last     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s.start) begin
          state_d   = ST_RUN;
          mode_d    = mode_t'(s.mode);
          x_d       = '0;
          y_d       = '0;
          in_done_d = 1'b0;
          dup_d     = 1'b0;
        end
      end

      ST_RUN: begin
        if (dup_q) begin
          if (out_free) begin
            ld    = 1'b1;
            dup_d = 1'b0;
            if (row_end_q) begin
              state_d   = ST_REPLAY;
              rep_idx_d = '0;
              rep_ph_d  = 1'b0;
            end
          end
        end else if (accept) begin
          prev_d = s.in_pixel;
          if (at_x_last) begin
            x_d = '0;
            if (at_y_last) begin
              y_d       = '0;
              in_done_d = 1'b1;
            end else begin
              y_d = y_q + YW'(1);
            end
          end else begin
            x_d = x_q + XW'(1);
          end

          case (mode_q)
            M_PASS: begin
              ld      = 1'b1;
              ld_pix  = s.in_pixel;
              ld_last = at_x_last && at_y_last;
            end
            M_DEC: begin
              ld      = !drop;
              ld_pix  = s.in_pixel;
              ld_last = (x_q == X_PEN) && (y_q == Y_PEN);
            end
            M_AVG: begin
              if (!y_q[0] && x_q[0]) begin
                wr_en   = 1'b1;
                wr_addr = x_q >> 1;
                wr_data = pair_sum;
              end
              ld      = !drop;
              ld_pix  = avg_pix;
              ld_last = at_x_last && at_y_last;
            end
            M_ZOOM: begin
              wr_en     = 1'b1;
              wr_addr   = x_q;
              wr_data   = {1'b0, s.in_pixel};
              ld        = 1'b1;
              ld_pix    = s.in_pixel;
              dup_d     = 1'b1;
              row_end_d = at_x_last;
            end
            default: ;
          endcase

          if (mode_q != M_ZOOM && at_x_last && at_y_last) state_d = ST_FLUSH;
        end
      end

      ST_REPLAY: begin
        if (out_free) begin
          ld     = 1'b1;
          ld_pix = rd_q[PIX_W-1:0];
          if (!rep_ph_q) begin
            rep_ph_d = 1'b1;
          end else begin
            rep_ph_d = 1'b0;
            if (rep_idx_q == X_LAST) begin
              rep_idx_d = '0;
              ld_last   = in_done_q;
              state_d   = in_done_q ? ST_FLUSH : ST_RUN;
            end else begin
              rep_idx_d = rep_idx_q + XW'(1);
            end
          end
        end
      end

      ST_FLUSH: begin
        if (out_free) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    out_valid_d = out_valid_q;
    out_pixel_d = out_pixel_q;
    out_last_d  = out_last_q;
    if (ld) begin
      out_valid_d = 1'b1;
      out_pixel_d = ld_pix;
      out_last_d  = ld_last;
    end else if (out_free) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    // Address for next cycle's read: replay index in REPLAY, pair slot of the next pixel otherwise.
    rd_addr = (state_d == ST_REPLAY) ? rep_idx_d : (x_d >> 1);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= M_PASS;
      x_q         <= '0;
      y_q         <= '0;
      in_done_q   <= 1'b0;
      dup_q       <= 1'b0;
      row_end_q   <= 1'b0;
      rep_idx_q   <= '0;
      rep_ph_q    <= 1'b0;
      prev_q      <= '0;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      x_q         <= x_d;
      y_q         <= y_d;
      in_done_q   <= in_done_d;
      dup_q       <= dup_d;
      row_end_q   <= row_end_d;
      rep_idx_q   <= rep_idx_d;
      rep_ph_q    <= rep_ph_d;
      prev_q      <= prev_d;
      out_valid_q <= out_valid_d;
      out_pixel_q <= out_pixel_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  // Line buffer: one write port, one synchronous read port.
  always_ff @(posedge clk) begin
    // NOTE: the buffer is deliberately not reset; every entry is written before it is read.
    if (wr_en) line_buf[wr_addr] <= wr_data;
    rd_q <= line_buf[rd_addr];
  end

  assign s.in_ready  = in_ready;
  assign s.out_valid = out_valid_q;
  assign s.out_pixel = out_pixel_q;
  assign s.out_last  = out_last_q;
  assign s.busy      = (state_q != ST_IDLE);
  assign s.done      = done_q;

endmodule

// File: tb/tb_scaler_stream_core.sv
// Self-checking bench for scaler_stream_core (PIX_W=8, IMG_W=4, IMG_H=4).
// Expected output streams come from a frame-level model built from the mode rules.
module tb_scaler_stream_core;

  localparam int PIX_W = 8;
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int NPIX  = IMG_W * IMG_H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scaler_stream_if #(.PIX_W(PIX_W)) bus ();

  scaler_stream_core #(.PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] frame [NPIX];
  logic [7:0] exp_q [$];
  logic [7:0] got   [64];
  int         in_stalls;
  logic       done_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Frame-level reference: whole-frame arithmetic, no notion of cycles.
  function automatic void build_model(input logic [1:0] m);
    int s;
    exp_q.delete();
    case (m)
      2'b00: for (int i = 0; i < NPIX; i++) exp_q.push_back(frame[i]);
      2'b01: for (int y = 0; y < IMG_H; y += 2)
               for (int x = 0; x < IMG_W; x += 2) exp_q.push_back(frame[y*IMG_W+x]);
      2'b10: for (int y = 0; y < IMG_H; y += 2)
               for (int x = 0; x < IMG_W; x += 2) begin
                 s = frame[y*IMG_W+x] + frame[y*IMG_W+x+1]
                   + frame[(y+1)*IMG_W+x] + frame[(y+1)*IMG_W+x+1];
`ifdef AVG_ROUND_EN
                 s = s + 2;
`endif
                 exp_q.push_back(8'(s / 4));
               end
      default: for (int y = 0; y < IMG_H; y++)
                 for (int r = 0; r < 2; r++)
                   for (int x = 0; x < IMG_W; x++) begin
                     exp_q.push_back(frame[y*IMG_W+x]);
                     exp_q.push_back(frame[y*IMG_W+x]);
                   end
    endcase
  endfunction

  task automatic fill_ramp();
    for (int y = 0; y < IMG_H; y++)
      for (int x = 0; x < IMG_W; x++) frame[y*IMG_W+x] = 8'(16*y + x);
  endtask

  // Runs one frame with throttled input/output; abort_at >= 0 stops after that many outputs.
  task automatic run_frame(input logic [1:0] m, input int in_pct, input int out_pct,
                           input int abort_at);
    int idx, oidx, cyc, last_hs, last_acc, exp_done, pos;
    logic held_valid;
    logic [7:0] held_pix;
    build_model(m);
    idx = 0; oidx = 0; cyc = 0; last_hs = -10; last_acc = -10;
    held_valid = 1'b0; held_pix = '0; in_stalls = 0; done_seen = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = m;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_start", bus.busy, 1'b1);
    while (!done_seen && cyc < 3000 && !(abort_at >= 0 && oidx >= abort_at)) begin
      bus.in_valid  = ($urandom_range(99) < in_pct);
      bus.in_pixel  = (idx < NPIX) ? frame[idx] : 8'hEE;
      bus.out_ready = ($urandom_range(99) < out_pct);
      #1;
      if (held_valid) begin
        check("stall_valid", bus.out_valid, 1'b1);
        check("stall_pixel", bus.out_pixel, held_pix);
      end
      if (bus.done) begin
        done_seen = 1'b1;
        exp_done  = (last_hs + 1 > last_acc + 2) ? last_hs + 1 : last_acc + 2;
        check("done_timing", cyc, exp_done);
        check("done_out_count", oidx, exp_q.size());
        check("busy_low_at_done", bus.busy, 1'b0);
      end
      if (bus.in_valid && idx >= NPIX) check("in_ready_after_final", bus.in_ready, 1'b0);
      if (m == 2'b11 && bus.out_valid) begin
        pos = oidx % (4*IMG_W);
        if (pos >= 2*IMG_W && pos < 4*IMG_W-1) check("in_ready_replay", bus.in_ready, 1'b0);
      end
      if (bus.in_valid && idx < NPIX) begin
        if (bus.in_ready) begin
          idx++;
          last_acc = cyc;
        end else begin
          in_stalls++;
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        if (oidx < exp_q.size()) begin
          check("pixel", bus.out_pixel, exp_q[oidx]);
          check("last", bus.out_last, oidx == exp_q.size() - 1);
        end else begin
          check("extra_output", oidx, exp_q.size());
        end
        if (oidx < 64) got[oidx] = bus.out_pixel;
        oidx++;
        last_hs = cyc;
      end
      held_valid = bus.out_valid && !bus.out_ready;
      held_pix   = bus.out_pixel;
      cyc++;
      @(negedge clk);
    end
    if (abort_at < 0) check("frame_done_seen", done_seen, 1'b1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0; bus.mode = 2'b00; bus.in_valid = 1'b0;
    bus.in_pixel = '0; bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_out_pixel", bus.out_pixel, 8'h00);
    check("rst_out_last", bus.out_last, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    rst = 1'b0;

    // Pass-through at full rate.
    fill_ramp();
    run_frame(2'b00, 100, 100, -1);
    check("pass_last_value", got[15], 8'h33);
    check("pass_no_in_stall", in_stalls, 0);

    // Decimate at full rate.
    run_frame(2'b01, 100, 100, -1);
    check("dec_out0", got[0], 8'h00);
    check("dec_out1", got[1], 8'h02);
    check("dec_out2", got[2], 8'h20);
    check("dec_out3", got[3], 8'h22);
    check("dec_no_in_stall", in_stalls, 0);

    // Average: an exact block and a rounding-sensitive block.
    fill_ramp();
    frame[0] = 8'd10;  frame[1] = 8'd11;  frame[4] = 8'd13;  frame[5] = 8'd14;
    frame[2] = 8'd255; frame[3] = 8'd255; frame[6] = 8'd255; frame[7] = 8'd254;
    run_frame(2'b10, 100, 100, -1);
    check("avg_block_exact", got[0], 8'd12);
`ifdef AVG_ROUND_EN
    check("avg_block_round", got[1], 8'd255);
`else
    check("avg_block_trunc", got[1], 8'd254);
`endif

    // Zoom with a 2x2 override in the top-left corner.
    fill_ramp();
    frame[0] = 8'd1; frame[1] = 8'd2; frame[4] = 8'd3; frame[5] = 8'd4;
    run_frame(2'b11, 100, 100, -1);
    check("zoom_r0_a", got[0], 8'd1);
    check("zoom_r0_b", got[1], 8'd1);
    check("zoom_r0_c", got[2], 8'd2);
    check("zoom_r0_d", got[3], 8'd2);
    check("zoom_rep_a", got[8], 8'd1);
    check("zoom_rep_c", got[10], 8'd2);
    check("zoom_r1_a", got[16], 8'd3);
    check("zoom_r1_c", got[18], 8'd4);

    // Random data and random throttling in every mode.
    for (int r = 0; r < 3; r++)
      for (int m = 0; m < 4; m++) begin
        for (int i = 0; i < NPIX; i++) frame[i] = 8'($urandom);
        run_frame(2'(m), 60, 55, -1);
      end

    // Reset in the middle of a zoom replay, then a clean pass frame.
    fill_ramp();
    run_frame(2'b11, 100, 100, 2*IMG_W + 1);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_in_ready", bus.in_ready, 1'b0);
    check("midrst_done", bus.done, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("midrst_no_done", bus.done, 1'b0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    run_frame(2'b00, 100, 100, -1);
    check("post_rst_first", got[0], 8'h00);
    check("post_rst_last", got[15], 8'h33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
